// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - single-outstanding Wishbone pipelined master driven by a valid/ready command stream
// Optional bus timeout abort is compiled in with `define WB_MASTER_TIMEOUT_EN.
module wb_cmd_master #(
  parameter int ADDR_WIDTH     = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_we,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [DATA_WIDTH-1:0] i_cmd_data,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_rsp_err,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [ADDR_WIDTH-1:0] o_wb_addr,
  output logic [DATA_WIDTH-1:0] o_wb_data,
  input  logic                  i_wb_ack,
  input  logic                  i_wb_stall,
  input  logic [DATA_WIDTH-1:0] i_wb_data
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_cmd_master: TIMEOUT_CYCLES must be 1..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t                state, state_next;
  logic                  cmd_ready_next;
  logic                  rsp_valid_next;
  logic                  rsp_err_next;
  logic [DATA_WIDTH-1:0] rsp_data_next;
  logic                  cyc_next;
  logic                  stb_next;
  logic                  we_next;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [DATA_WIDTH-1:0] wdata_next;
  logic                  complete;
  logic                  expire;

  // An ack only counts once the strobe has been taken (stall low) or in ACK.
  always_comb begin
    complete = 1'b0;
    if (state == S_REQ)
      complete = !i_wb_stall && i_wb_ack;
    else if (state == S_ACK)
      complete = i_wb_ack;
  end

`ifdef WB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] tmo_cnt;
  logic [15:0] tmo_cnt_inc;

  assign tmo_cnt_inc = tmo_cnt + 16'd1;
  // Completion takes priority, so an ack on the expiry edge still finishes normally.
  assign expire = (state != S_IDLE) && !complete && (tmo_cnt_inc == TIMEOUT_LIMIT);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      tmo_cnt <= '0;
    else if (state == S_IDLE)
      tmo_cnt <= '0;
    else if (!complete)
      tmo_cnt <= tmo_cnt_inc;
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_next     = state;
    cmd_ready_next = 1'b0;
    rsp_valid_next = 1'b0;
    rsp_err_next   = 1'b0;
    rsp_data_next  = o_rsp_data;
    cyc_next       = o_wb_cyc;
    stb_next       = o_wb_stb;
    we_next        = o_wb_we;
    addr_next      = o_wb_addr;
    wdata_next     = o_wb_data;

    case (state)
      S_IDLE: begin
        cmd_ready_next = 1'b1;
        if (i_cmd_valid) begin
          state_next     = S_REQ;
          cmd_ready_next = 1'b0;
          cyc_next       = 1'b1;
          stb_next       = 1'b1;
          we_next        = i_cmd_we;
          addr_next      = i_cmd_addr;
          wdata_next     = i_cmd_data;
        end
      end
      S_REQ: begin
        if (!i_wb_stall) begin
          stb_next   = 1'b0;
          state_next = S_ACK;
        end
      end
      S_ACK: begin
        state_next = S_ACK;
      end
      default: begin
        state_next     = S_IDLE;
        cmd_ready_next = 1'b1;
        cyc_next       = 1'b0;
        stb_next       = 1'b0;
      end
    endcase

    if (complete) begin
      state_next     = S_IDLE;
      cmd_ready_next = 1'b1;
      cyc_next       = 1'b0;
      stb_next       = 1'b0;
      rsp_valid_next = 1'b1;
      rsp_data_next  = o_wb_we ? '0 : i_wb_data;
    end else if (expire) begin
      state_next     = S_IDLE;
      cmd_ready_next = 1'b1;
      cyc_next       = 1'b0;
      stb_next       = 1'b0;
      rsp_valid_next = 1'b1;
      rsp_err_next   = 1'b1;
      rsp_data_next  = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= S_IDLE;
      o_cmd_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_rsp_data  <= '0;
      o_wb_cyc    <= 1'b0;
      o_wb_stb    <= 1'b0;
      o_wb_we     <= 1'b0;
      o_wb_addr   <= '0;
      o_wb_data   <= '0;
    end else begin
      state       <= state_next;
      o_cmd_ready <= cmd_ready_next;
      o_rsp_valid <= rsp_valid_next;
      o_rsp_err   <= rsp_err_next;
      o_rsp_data  <= rsp_data_next;
      o_wb_cyc    <= cyc_next;
      o_wb_stb    <= stb_next;
      o_wb_we     <= we_next;
      o_wb_addr   <= addr_next;
      o_wb_data   <= wdata_next;
    end
  end

endmodule
